lift_request_panel: RTL and testbench

- Hall/car button front end for liftcontroller: the other end of its up_button/down_button/inside_button request bus and its reset_up/reset_down/reset_inside_button clear bus.
- Synchronises and debounces raw push-buttons, latches each press as a sticky request bit that drives the controller, and drops a request when the controller asserts the matching clear.
- Also decodes the controller's one-hot present_floor into a binary floor number for the indicator, and emits an arrival pulse on each floor change.

---
 rtl/lift_request_panel.sv | 128 ++++++++++++
 tb/tb_lift_request_panel.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lift_request_panel.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lift_request_panel: button sync/debounce, sticky requests, floor decode     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module lift_request_panel #(
  parameter int N_FLOORS   = 7,
  parameter int DEB_CYCLES = 4,
  parameter int FLOOR_W    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_FLOORS-1:0] raw_up,
  input  logic [N_FLOORS-1:0] raw_down,
  input  logic [N_FLOORS-1:0] raw_inside,
  input  logic [N_FLOORS-1:0] reset_up,
  input  logic [N_FLOORS-1:0] reset_down,
  input  logic [N_FLOORS-1:0] reset_inside_button,
  input  logic [N_FLOORS-1:0] present_floor,
  output logic [N_FLOORS-1:0] up_button,
  output logic [N_FLOORS-1:0] down_button,
  output logic [N_FLOORS-1:0] inside_button,
  output logic [FLOOR_W-1:0]  floor_num,
  output logic                floor_valid,
  output logic                floor_change
);

  localparam int NCH   = 3 * N_FLOORS;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  localparam logic [0:0] STABLE_LO = 1'b0;
  localparam logic [0:0] STABLE_HI = 1'b1;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] UP_MASK   = ~(N_FLOORS'(1) << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] DOWN_MASK = ~N_FLOORS'(1);

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] clr_all;
  logic [NCH-1:0] req_all;

  assign raw_all = {raw_inside, raw_down, raw_up};
  assign clr_all = {reset_inside_button, reset_down, reset_up};

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_chan
      logic             sync1;
      logic             sync2;
      logic [0:0]       state;
      logic [CNT_W-1:0] cnt;
      logic             req;
      logic             mismatch;
      logic             flip;
      logic             press;

      assign mismatch = (sync2 != (state == STABLE_HI));
      assign flip     = mismatch && (cnt == CNT_LAST);
      // The press is taken from the switching cycle so the request lands on the same edge as deb.
      assign press    = flip && (state == STABLE_LO);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          state <= STABLE_LO;
          cnt   <= '0;
          req   <= 1'b0;
        end else begin
          sync1 <= raw_all[k];
          sync2 <= sync1;
          if (!mismatch) begin
            cnt <= '0;
          end else if (flip) begin
            cnt   <= '0;
            state <= (state == STABLE_LO) ? STABLE_HI : STABLE_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (clr_all[k]) begin
            req <= 1'b0;
          end else if (press) begin
            req <= 1'b1;
          end
        end
      end

      assign req_all[k] = req;
    end
  endgenerate

  // No up call exists at the top floor and no down call at the ground floor.
  assign up_button     = req_all[N_FLOORS-1:0] & UP_MASK;
  assign down_button   = req_all[2*N_FLOORS-1:N_FLOORS] & DOWN_MASK;
  assign inside_button = req_all[3*N_FLOORS-1:2*N_FLOORS];

  logic               onehot;
  logic [FLOOR_W-1:0] idx;
  logic               seen_valid;

  always_comb begin
    onehot = (present_floor != '0) &&
             ((present_floor & (present_floor - N_FLOORS'(1))) == '0);
    idx = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (present_floor[i]) begin
        idx = FLOOR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      floor_num    <= '0;
      floor_valid  <= 1'b0;
      floor_change <= 1'b0;
      seen_valid   <= 1'b0;
    end else begin
      floor_valid  <= onehot;
      floor_change <= onehot && (!seen_valid || (idx != floor_num));
      if (onehot) begin
        floor_num  <= idx;
        seen_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lift_request_panel.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_lift_request_panel: directed self-checking bench for lift_request_panel  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_lift_request_panel;

  logic       clk;
  logic       reset_n;
  logic [6:0] raw_up;
  logic [6:0] raw_down;
  logic [6:0] raw_inside;
  logic [6:0] reset_up;
  logic [6:0] reset_down;
  logic [6:0] reset_inside_button;
  logic [6:0] present_floor;
  logic [6:0] up_button;
  logic [6:0] down_button;
  logic [6:0] inside_button;
  logic [2:0] floor_num;
  logic       floor_valid;
  logic       floor_change;

  int total = 0;
  int passed = 0;

  lift_request_panel #(
    .N_FLOORS  (7),
    .DEB_CYCLES(4),
    .FLOOR_W   (3)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .raw_up             (raw_up),
    .raw_down           (raw_down),
    .raw_inside         (raw_inside),
    .reset_up           (reset_up),
    .reset_down         (reset_down),
    .reset_inside_button(reset_inside_button),
    .present_floor      (present_floor),
    .up_button          (up_button),
    .down_button        (down_button),
    .inside_button      (inside_button),
    .floor_num          (floor_num),
    .floor_valid        (floor_valid),
    .floor_change       (floor_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_up = '0; raw_down = '0; raw_inside = '0;
    reset_up = '0; reset_down = '0; reset_inside_button = '0;
    present_floor = '0;
    #1;
    chk("rst_up", up_button, 0);
    chk("rst_down", down_button, 0);
    chk("rst_inside", inside_button, 0);
    chk("rst_fnum", floor_num, 0);
    chk("rst_fvalid", floor_valid, 0);
    chk("rst_fchange", floor_change, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("idle_fvalid", floor_valid, 0);

    // Latency: request visible after edge 6, not before
    raw_inside[3] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("lat_inside_e%0d", e), inside_button, 0);
    end
    tick();
    chk("lat_inside_e6", inside_button, 7'b0001000);

    // Clear while still held
    reset_inside_button[3] = 1'b1;
    tick();
    chk("clr_inside", inside_button, 0);
    reset_inside_button[3] = 1'b0;
    tick(10);
    chk("clr_held_no_relatch", inside_button, 0);
    raw_inside[3] = 1'b0;
    tick(10);
    chk("clr_released", inside_button, 0);
    raw_inside[3] = 1'b1;
    tick(5);
    chk("repress_e5", inside_button, 0);
    tick();
    chk("repress_e6", inside_button, 7'b0001000);
    raw_inside[3] = 1'b0;
    tick(12);
    chk("sticky_after_release", inside_button, 7'b0001000);

    // Bounce: 3-high/1-low pattern never latches
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int c = 0; c < 8; c++) begin
        raw_up[2] = pat[c];
        tick();
        chk($sformatf("bounce_c%0d", c), up_button, 0);
      end
    end
    raw_up[2] = 1'b0;
    tick(6);
    chk("bounce_settled", up_button, 0);
    raw_up[2] = 1'b1;
    tick(5);
    chk("steady_e5", up_button, 0);
    tick();
    chk("steady_e6", up_button, 7'b0000100);
    raw_up[2] = 1'b0;
    tick(8);

    // Clear dominance: clear coincides with the press cycle
    raw_down[4] = 1'b1;
    tick(5);
    chk("dom_pre", down_button, 0);
    reset_down[4] = 1'b1;
    tick();
    reset_down[4] = 1'b0;
    chk("dom_discard", down_button, 0);
    tick(6);
    chk("dom_no_defer", down_button, 0);
    raw_down[4] = 1'b0;
    tick(8);

    // Masked positions
    raw_up[6] = 1'b1;
    raw_down[0] = 1'b1;
    tick(20);
    chk("mask_up", up_button, 7'b0000100);
    chk("mask_down", down_button, 0);
    raw_up[6] = 1'b0;
    raw_down[0] = 1'b0;
    tick(8);

    // Floor decode
    present_floor = 7'b0000001;
    tick();
    chk("f0_num", floor_num, 0);
    chk("f0_valid", floor_valid, 1);
    chk("f0_change", floor_change, 1);
    present_floor = 7'b0000100;
    tick();
    chk("f2_num", floor_num, 2);
    chk("f2_valid", floor_valid, 1);
    chk("f2_change", floor_change, 1);
    present_floor = 7'b0000110;
    tick();
    chk("bad_num", floor_num, 2);
    chk("bad_valid", floor_valid, 0);
    chk("bad_change", floor_change, 0);
    present_floor = 7'b0000100;
    tick();
    chk("f2b_num", floor_num, 2);
    chk("f2b_valid", floor_valid, 1);
    chk("f2b_change", floor_change, 0);

    // Asynchronous reset mid-cycle with lamps lit
    chk("pre_rst_lamps", {up_button, inside_button}, {7'b0000100, 7'b0001000});
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_up", up_button, 0);
    chk("async_inside", inside_button, 0);
    chk("async_fnum", floor_num, 0);
    chk("async_fvalid", floor_valid, 0);
    tick(2);
    reset_n = 1'b1;
    present_floor = '0;
    tick(3);
    chk("post_rst_lamps", {up_button, down_button, inside_button}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
